// File: rtl/vectored_int_ctrl.sv
// N-channel vectored priority interrupt controller with edge/level capture, mask and in-service
// tracking. Optional nesting (preemption by higher priority) enabled by defining INT_NESTING_EN.
module vectored_int_ctrl #(
  parameter int unsigned       N_CH       = 8,
  parameter int unsigned       VEC_W      = 8,
  parameter logic [VEC_W-1:0]  VEC_BASE   = VEC_W'(8'hF0),
  parameter int unsigned       VEC_STRIDE = 2
) (
  input  logic             g_clk,
  input  logic             g_clr,
  input  logic [N_CH-1:0]  int_src,
  input  logic [N_CH-1:0]  edge_sel,
  input  logic [N_CH-1:0]  mask_in,
  input  logic             mask_ld,
  input  logic             ien,
  input  logic             int_ack,
  input  logic             eoi,
  output logic             i_pending,
  output logic [VEC_W-1:0] vector_out,
  output logic [N_CH-1:0]  in_service,
  output logic [N_CH-1:0]  irq_lost
);

  localparam int unsigned IdW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e          state_q, state_d;
  logic [IdW-1:0]  id_q, id_d;
  logic [N_CH-1:0] src_q, src_qq;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] mask_q, mask_d;
  logic [N_CH-1:0] isr_q, isr_d;
  logic [N_CH-1:0] lost_q, lost_d;

  logic [N_CH-1:0] edge_det, elig, isr_low, ack_set;
  logic            win_vld, gate_ok;
  logic [IdW-1:0]  win_id;

  assign edge_det = src_q & ~src_qq;
  assign elig     = pend_q & mask_q;
  // Isolates the lowest set bit, i.e. the highest-priority channel in service.
  assign isr_low  = isr_q & (~isr_q + N_CH'(1));

  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_vld = 1'b1;
        win_id  = IdW'(i);
      end
    end
  end

`ifdef INT_NESTING_EN
  logic [IdW-1:0] isr_id;

  always_comb begin
    isr_id = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (isr_q[i]) isr_id = IdW'(i);
    end
  end

  assign gate_ok = (isr_q == '0) || (win_id < isr_id);
`else
  assign gate_ok = (isr_q == '0);
`endif

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ack_set = '0;
    unique case (state_q)
      StIdle: begin
        if (ien && win_vld && gate_ok) begin
          state_d = StReq;
          id_d    = win_id;
        end
      end
      StReq: begin
        // Committed request: only int_ack (or reset) releases it.
        if (int_ack) begin
          state_d      = StIdle;
          ack_set[id_q] = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pend_d = (edge_sel & ((pend_q & ~ack_set) | edge_det)) | (~edge_sel & src_q);
    lost_d = lost_q | (edge_sel & edge_det & pend_q & ~ack_set);
    mask_d = mask_ld ? mask_in : mask_q;
    // EOI retires against the old ISR before the acknowledged channel is added.
    isr_d  = (isr_q & ~(eoi ? isr_low : '0)) | ack_set;
  end

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      state_q <= StIdle;
      id_q    <= '0;
      src_q   <= '0;
      src_qq  <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      isr_q   <= '0;
      lost_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      src_q   <= int_src;
      src_qq  <= src_q;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      isr_q   <= isr_d;
      lost_q  <= lost_d;
    end
  end

  assign i_pending  = (state_q == StReq);
  assign vector_out = VEC_BASE + VEC_W'(32'(id_q) * VEC_STRIDE);
  assign in_service = isr_q;
  assign irq_lost   = lost_q;

endmodule

// File: tb/tb_vectored_int_ctrl.sv
// Directed table-driven bench for vectored_int_ctrl (default parameters), with hand-written
// sequences for nesting behaviour and asynchronous reset during a pending request.
module tb_vectored_int_ctrl;

  logic       clk = 1'b0;
  logic       g_clr;
  logic [7:0] int_src, edge_sel, mask_in;
  logic       mask_ld, ien, int_ack, eoi;
  logic       i_pending;
  logic [7:0] vector_out, in_service, irq_lost;

  int n_vec = 0;
  int n_err = 0;

  vectored_int_ctrl dut (
    .g_clk      (clk),
    .g_clr      (g_clr),
    .int_src    (int_src),
    .edge_sel   (edge_sel),
    .mask_in    (mask_in),
    .mask_ld    (mask_ld),
    .ien        (ien),
    .int_ack    (int_ack),
    .eoi        (eoi),
    .i_pending  (i_pending),
    .vector_out (vector_out),
    .in_service (in_service),
    .irq_lost   (irq_lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] src, esel, mask;
    logic       ld, ie, ack, eo;
    logic       x_ip;
    logic [7:0] x_vec, x_isr, x_lost;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [7:0] s, e, m, input logic l, i, a, o,
                              input logic xp, input logic [7:0] xv, xi, xl);
    vec_t v;
    v.src = s; v.esel = e; v.mask = m; v.ld = l; v.ie = i; v.ack = a; v.eo = o;
    v.x_ip = xp; v.x_vec = xv; v.x_isr = xi; v.x_lost = xl;
    return v;
  endfunction

  task automatic check(input string nm, input logic xp, input logic [7:0] xv, xi, xl);
    n_vec++;
    if (i_pending !== xp || vector_out !== xv || in_service !== xi || irq_lost !== xl) begin
      n_err++;
      $display("FAIL %s: got ip=%b vec=%h isr=%h lost=%h, want ip=%b vec=%h isr=%h lost=%h",
               nm, i_pending, vector_out, in_service, irq_lost, xp, xv, xi, xl);
    end
  endtask

  task automatic step(input string nm, input logic [7:0] s, e, m, input logic l, i, a, o,
                      input logic xp, input logic [7:0] xv, xi, xl);
    int_src = s; edge_sel = e; mask_in = m; mask_ld = l; ien = i; int_ack = a; eoi = o;
    @(posedge clk);
    #1;
    check(nm, xp, xv, xi, xl);
  endtask

  initial begin
    g_clr = 1'b0;
    int_src = '0; edge_sel = '0; mask_in = '0;
    mask_ld = 1'b0; ien = 1'b0; int_ack = 1'b0; eoi = 1'b0;

    // Edge-mode channel 3: request on the third edge, then ack and eoi.
    tbl.push_back(mk(8'h00, 8'hFF, 8'hFF, 1, 1, 0, 0, 0, 8'hF0, 8'h00, 8'h00));
    tbl.push_back(mk(8'h08, 8'hFF, 8'hFF, 0, 1, 0, 0, 0, 8'hF0, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'hFF, 0, 1, 0, 0, 0, 8'hF0, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'hFF, 0, 1, 0, 0, 1, 8'hF6, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'hFF, 0, 1, 1, 0, 0, 8'hF6, 8'h08, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'hFF, 0, 1, 0, 1, 0, 8'hF6, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'hFF, 0, 1, 0, 0, 0, 8'hF6, 8'h00, 8'h00));
    // Level channels 5 and 2 together: 2 wins, then 5 once 2 is withdrawn and retired.
    tbl.push_back(mk(8'h24, 8'h00, 8'hFF, 0, 1, 0, 0, 0, 8'hF6, 8'h00, 8'h00));
    tbl.push_back(mk(8'h24, 8'h00, 8'hFF, 0, 1, 0, 0, 0, 8'hF6, 8'h00, 8'h00));
    tbl.push_back(mk(8'h24, 8'h00, 8'hFF, 0, 1, 0, 0, 1, 8'hF4, 8'h00, 8'h00));
    tbl.push_back(mk(8'h20, 8'h00, 8'hFF, 0, 1, 1, 0, 0, 8'hF4, 8'h04, 8'h00));
    tbl.push_back(mk(8'h20, 8'h00, 8'hFF, 0, 1, 0, 1, 0, 8'hF4, 8'h00, 8'h00));
    tbl.push_back(mk(8'h20, 8'h00, 8'hFF, 0, 1, 0, 0, 1, 8'hFA, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 8'hFF, 0, 1, 1, 0, 0, 8'hFA, 8'h20, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 8'hFF, 0, 1, 0, 1, 0, 8'hFA, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 8'hFF, 0, 1, 0, 0, 0, 8'hFA, 8'h00, 8'h00));
    // Channel 4 masked, three edges: captured once, lost flagged, one request on unmask.
    tbl.push_back(mk(8'h00, 8'hFF, 8'hEF, 1, 1, 0, 0, 0, 8'hFA, 8'h00, 8'h00));
    tbl.push_back(mk(8'h10, 8'hFF, 8'hEF, 0, 1, 0, 0, 0, 8'hFA, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'hEF, 0, 1, 0, 0, 0, 8'hFA, 8'h00, 8'h00));
    tbl.push_back(mk(8'h10, 8'hFF, 8'hEF, 0, 1, 0, 0, 0, 8'hFA, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 8'hFF, 8'hEF, 0, 1, 0, 0, 0, 8'hFA, 8'h00, 8'h10));
    tbl.push_back(mk(8'h10, 8'hFF, 8'hEF, 0, 1, 0, 0, 0, 8'hFA, 8'h00, 8'h10));
    tbl.push_back(mk(8'h00, 8'hFF, 8'hEF, 0, 1, 0, 0, 0, 8'hFA, 8'h00, 8'h10));
    tbl.push_back(mk(8'h00, 8'hFF, 8'hFF, 1, 1, 0, 0, 0, 8'hFA, 8'h00, 8'h10));
    tbl.push_back(mk(8'h00, 8'hFF, 8'hFF, 0, 1, 0, 0, 1, 8'hF8, 8'h00, 8'h10));
    tbl.push_back(mk(8'h00, 8'hFF, 8'hFF, 0, 1, 1, 0, 0, 8'hF8, 8'h10, 8'h10));
    tbl.push_back(mk(8'h00, 8'hFF, 8'hFF, 0, 1, 0, 1, 0, 8'hF8, 8'h00, 8'h10));
    tbl.push_back(mk(8'h00, 8'hFF, 8'hFF, 0, 1, 0, 0, 0, 8'hF8, 8'h00, 8'h10));
    // Channel 2 committed: clearing mask and ien does not retract it.
    tbl.push_back(mk(8'h04, 8'hFF, 8'hFF, 0, 1, 0, 0, 0, 8'hF8, 8'h00, 8'h10));
    tbl.push_back(mk(8'h00, 8'hFF, 8'hFF, 0, 1, 0, 0, 0, 8'hF8, 8'h00, 8'h10));
    tbl.push_back(mk(8'h00, 8'hFF, 8'hFF, 0, 1, 0, 0, 1, 8'hF4, 8'h00, 8'h10));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h00, 1, 0, 0, 0, 1, 8'hF4, 8'h00, 8'h10));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h00, 0, 0, 0, 0, 1, 8'hF4, 8'h00, 8'h10));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h00, 0, 0, 1, 0, 0, 8'hF4, 8'h04, 8'h10));
    tbl.push_back(mk(8'h00, 8'hFF, 8'h00, 0, 0, 0, 1, 0, 8'hF4, 8'h00, 8'h10));

    #1;
    check("reset", 1'b0, 8'hF0, 8'h00, 8'h00);
    @(negedge clk);
    g_clr = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("tbl[%0d]", i), tbl[i].src, tbl[i].esel, tbl[i].mask, tbl[i].ld,
           tbl[i].ie, tbl[i].ack, tbl[i].eo, tbl[i].x_ip, tbl[i].x_vec, tbl[i].x_isr,
           tbl[i].x_lost);
    end

    // Channel 1 in service, then an edge on channel 0.
    step("n_ld1",  8'h02, 8'hFF, 8'hFF, 1, 1, 0, 0, 0, 8'hF4, 8'h00, 8'h10);
    step("n_cap1", 8'h00, 8'hFF, 8'hFF, 0, 1, 0, 0, 0, 8'hF4, 8'h00, 8'h10);
    step("n_req1", 8'h00, 8'hFF, 8'hFF, 0, 1, 0, 0, 1, 8'hF2, 8'h00, 8'h10);
    step("n_ack1", 8'h00, 8'hFF, 8'hFF, 0, 1, 1, 0, 0, 8'hF2, 8'h02, 8'h10);
    step("n_src0", 8'h01, 8'hFF, 8'hFF, 0, 1, 0, 0, 0, 8'hF2, 8'h02, 8'h10);
    step("n_cap0", 8'h00, 8'hFF, 8'hFF, 0, 1, 0, 0, 0, 8'hF2, 8'h02, 8'h10);
`ifdef INT_NESTING_EN
    step("n_pre0", 8'h00, 8'hFF, 8'hFF, 0, 1, 0, 0, 1, 8'hF0, 8'h02, 8'h10);
    step("n_ack0", 8'h00, 8'hFF, 8'hFF, 0, 1, 1, 0, 0, 8'hF0, 8'h03, 8'h10);
    step("n_eoi0", 8'h00, 8'hFF, 8'hFF, 0, 1, 0, 1, 0, 8'hF0, 8'h02, 8'h10);
    step("n_eoi1", 8'h00, 8'hFF, 8'hFF, 0, 1, 0, 1, 0, 8'hF0, 8'h00, 8'h10);
    // Channel 3 in service, channel 2 preempts, then eoi and ack together.
    step("s_src3", 8'h08, 8'hFF, 8'hFF, 0, 1, 0, 0, 0, 8'hF0, 8'h00, 8'h10);
    step("s_cap3", 8'h00, 8'hFF, 8'hFF, 0, 1, 0, 0, 0, 8'hF0, 8'h00, 8'h10);
    step("s_req3", 8'h00, 8'hFF, 8'hFF, 0, 1, 0, 0, 1, 8'hF6, 8'h00, 8'h10);
    step("s_ack3", 8'h04, 8'hFF, 8'hFF, 0, 1, 1, 0, 0, 8'hF6, 8'h08, 8'h10);
    step("s_cap2", 8'h00, 8'hFF, 8'hFF, 0, 1, 0, 0, 0, 8'hF6, 8'h08, 8'h10);
    step("s_req2", 8'h00, 8'hFF, 8'hFF, 0, 1, 0, 0, 1, 8'hF4, 8'h08, 8'h10);
    step("s_both", 8'h00, 8'hFF, 8'hFF, 0, 1, 1, 1, 0, 8'hF4, 8'h04, 8'h10);
    step("s_eoi2", 8'h00, 8'hFF, 8'hFF, 0, 1, 0, 1, 0, 8'hF4, 8'h00, 8'h10);
`else
    step("n_blk0", 8'h00, 8'hFF, 8'hFF, 0, 1, 0, 0, 0, 8'hF2, 8'h02, 8'h10);
    step("n_blk1", 8'h00, 8'hFF, 8'hFF, 0, 1, 0, 0, 0, 8'hF2, 8'h02, 8'h10);
    step("n_eoi1", 8'h00, 8'hFF, 8'hFF, 0, 1, 0, 1, 0, 8'hF2, 8'h00, 8'h10);
    step("n_req0", 8'h00, 8'hFF, 8'hFF, 0, 1, 0, 0, 1, 8'hF0, 8'h00, 8'h10);
    step("n_ack0", 8'h00, 8'hFF, 8'hFF, 0, 1, 1, 0, 0, 8'hF0, 8'h01, 8'h10);
    step("n_eoi0", 8'h00, 8'hFF, 8'hFF, 0, 1, 0, 1, 0, 8'hF0, 8'h00, 8'h10);
`endif

    // Reset in the middle of a presented request.
    step("r_src2", 8'h04, 8'hFF, 8'hFF, 0, 1, 0, 0, 0, 8'hF0, 8'h00, 8'h10);
    step("r_cap2", 8'h00, 8'hFF, 8'hFF, 0, 1, 0, 0, 0, 8'hF0, 8'h00, 8'h10);
    step("r_req2", 8'h00, 8'hFF, 8'hFF, 0, 1, 0, 0, 1, 8'hF4, 8'h00, 8'h10);
    #2;
    g_clr = 1'b0;
    #1;
    check("r_clr", 1'b0, 8'hF0, 8'h00, 8'h00);
    @(negedge clk);
    g_clr = 1'b1;
    step("r_psrc", 8'h04, 8'hFF, 8'hFF, 0, 1, 0, 0, 0, 8'hF0, 8'h00, 8'h00);
    step("r_pcap", 8'h00, 8'hFF, 8'hFF, 0, 1, 0, 0, 0, 8'hF0, 8'h00, 8'h00);
    step("r_msk0", 8'h00, 8'hFF, 8'hFF, 0, 1, 0, 0, 0, 8'hF0, 8'h00, 8'h00);
    step("r_msk1", 8'h00, 8'hFF, 8'hFF, 0, 1, 0, 0, 0, 8'hF0, 8'h00, 8'h00);
    step("r_reld", 8'h00, 8'hFF, 8'hFF, 1, 1, 0, 0, 0, 8'hF0, 8'h00, 8'h00);
    step("r_req",  8'h00, 8'hFF, 8'hFF, 0, 1, 0, 0, 1, 8'hF4, 8'h00, 8'h00);
    step("r_ack",  8'h00, 8'hFF, 8'hFF, 0, 1, 1, 0, 0, 8'hF4, 8'h04, 8'h00);
    step("r_eoi",  8'h00, 8'hFF, 8'hFF, 0, 1, 0, 1, 0, 8'hF4, 8'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
